maze_loc_datapath: RTL and testbench
====================================

Name: maze_loc_datapath

Overview:
- Location datapath for a 16x16 grid walker.
- Holds the current location as an 8-bit pair: x = bits [7:4], y = bits [3:0].
- Computes the neighbouring location for a 2-bit direction and flags grid-edge moves.
- Keeps a LIFO stack of visited locations for backtracking; driven by an external controller FSM.

Parameters:
- DEPTH, 64, number of 8-bit entries in the location stack (power of two, ≥2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- rgLd  input  1  load nxtLoc into the location registers at the next rising edge.
- dir  input  2  move direction.
- push  input  1  push curLoc onto the stack at the next rising edge.
- pop  input  1  select the stack top onto nxtLoc; remove it at the next rising edge.
- adderEn  input  1  enable the step adder; selects the adder result onto nxtLoc.
- cntReach  output  1  the move in dir would leave the grid (edge).
- empStck  output  1  stack holds zero entries.
- fullStck  output  1  stack holds DEPTH entries.
- nxtLoc  output  8  candidate next location (combinational).
- curLoc  output  8  registered current location.

Behaviour:
- Reset (rst=0, asynchronous):
  - curLoc = 8'h00.
  - Stack pointer = 0, so empStck=1 and fullStck=0.
  - Stack contents are don't-care.
  - Reset dominates all other inputs.
- Direction decode:
  - sel_x = dir[1]^dir[0]. sel_x=1 operates on x, sel_x=0 operates on y.
  - Step = +1 when dir[0]=1, -1 when dir[0]=0.
  - dir 00: y-1. dir 01: x+1. dir 10: x-1. dir 11: y+1.
- Step adder:
  - 4-bit sum = operand + step; carry is discarded (wrap-around).
  - Output is forced to 0 when adderEn=0.
- cntReach: purely combinational, independent of adderEn.
  - Equals ((operand + dir[0]) mod 16 == 0).
  - That is: operand==15 for a +1 move, operand==0 for a -1 move.
- nxtLoc: combinational mux, priority order:
  1. pop=1 and stack non-empty: stack top.
  2. pop=1 and stack empty: 8'h00.
  3. adderEn=1, sel_x=1: {sum, curLoc[3:0]}.
  4. adderEn=1, sel_x=0: {curLoc[7:4], sum}.
  5. Otherwise: curLoc (no latch).
  - While rst=0, nxtLoc = 8'h00.
- Location registers: two 4-bit registers (x, y) share rgLd; on a rising edge with rgLd=1, curLoc <= nxtLoc.
- Stack, one operation per clock:
  - push=1, pop=0, not full: mem[sp] <= curLoc (pre-edge value), sp++.
  - push while full: ignored; contents and sp unchanged.
  - pop=1, not empty: sp--; the top value is visible on nxtLoc combinationally before the edge.
  - pop while empty: ignored; sp stays 0.
  - push and pop together: pop wins, push ignored.
  - empStck = (sp==0); fullStck = (sp==DEPTH); both combinational from sp.
- pop with rgLd in the same cycle: curLoc takes the popped value and the entry is removed atomically.
- push with rgLd in the same cycle: the old curLoc is pushed and the new location is loaded.
- Latency:
  - cntReach and nxtLoc: 0 cycles (combinational).
  - curLoc and stack state: update on the edge following the request.

Test Plan:
1. Reset, then release with curLoc=0x00.
   - dir=00 → cntReach=1.
   - dir=01, adderEn=1 → nxtLoc=0x10, cntReach=0.
   - rgLd pulse → curLoc=0x10.
2. Walk to the corner: load 0xF5.
   - dir=01 → cntReach=1, nxtLoc=0x05 (wrap).
   - dir=11 → cntReach=0, nxtLoc=0xF6.
   - dir=10 → nxtLoc=0xE5.
3. Stack LIFO: at curLoc 0x12 push; move to 0x34 and push; load 0x56.
   - pop → nxtLoc=0x34 combinationally; with rgLd, curLoc=0x34.
   - Second pop → 0x12, then empStck=1.
4. Underflow/overflow:
   - pop on empty stack → nxtLoc=0x00, empStck stays 1.
   - Push DEPTH+1 times → fullStck=1 after DEPTH pushes; the extra push does not change the top value.
5. Priority: with the stack non-empty, assert pop and adderEn together → nxtLoc = stack top.
   - push and pop together → sp decrements only.
6. Asynchronous reset mid-operation: with stack depth 3 and curLoc=0x77, drop rst between edges.
   - curLoc=0x00 and empStck=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/maze_loc_datapath_if.sv
// Control and status bundle between the walker controller FSM and the location datapath.
interface maze_loc_datapath_if;
    logic       rgLd;
    logic [1:0] dir;
    logic       push;
    logic       pop;
    logic       adderEn;
    logic       cntReach;
    logic       empStck;
    logic       fullStck;
    logic [7:0] nxtLoc;
    logic [7:0] curLoc;

    modport master (
        output rgLd, dir, push, pop, adderEn,
        input  cntReach, empStck, fullStck, nxtLoc, curLoc
    );

    modport slave (
        input  rgLd, dir, push, pop, adderEn,
        output cntReach, empStck, fullStck, nxtLoc, curLoc
    );
endinterface

// File: rtl/maze_loc_datapath.sv
// Location datapath for a 16x16 grid walker: current location, step adder with
// edge detect, and a LIFO of visited locations for backtracking.
module maze_loc_datapath #(
    parameter int DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst,
    maze_loc_datapath_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = AW + 1;

    logic [3:0]    x_cur;
    logic [3:0]    y_cur;
    logic [SW-1:0] sp_reg;
    logic [SW-1:0] sp_next;
    logic [SW-1:0] sp_dec;
    logic [7:0]    mem [DEPTH];

    logic          sel_x;
    logic [3:0]    operand;
    logic [3:0]    step_val;
    logic [3:0]    sum;
    logic [3:0]    edge_sum;
    logic [7:0]    top;
    logic [7:0]    nxt_loc;
    logic          empty;
    logic          full;
    logic          do_push;
    logic          do_pop;
    logic [AW-1:0] top_idx;
    logic [AW-1:0] wr_idx;

    // Odd-parity directions (01, 10) move along x; the low bit picks +1 or -1.
    assign sel_x    = bus.dir[1] ^ bus.dir[0];
    assign operand  = sel_x ? x_cur : y_cur;
    assign step_val = bus.dir[0] ? 4'h1 : 4'hF;
    assign sum      = bus.adderEn ? (operand + step_val) : 4'h0;
    assign edge_sum = operand + {3'b000, bus.dir[0]};

    assign empty   = (sp_reg == '0);
    assign full    = (sp_reg == SW'(DEPTH));
    assign sp_dec  = sp_reg - SW'(1);
    assign top_idx = sp_dec[AW-1:0];
    assign wr_idx  = sp_reg[AW-1:0];
    assign top     = mem[top_idx];

    assign do_pop  = rst && bus.pop && !empty;
    assign do_push = rst && bus.push && !bus.pop && !full;

    always_comb begin
        nxt_loc = {x_cur, y_cur};
        if (!rst) begin
            nxt_loc = 8'h00;
        end else if (bus.pop) begin
            nxt_loc = empty ? 8'h00 : top;
        end else if (bus.adderEn) begin
            nxt_loc = sel_x ? {sum, y_cur} : {x_cur, sum};
        end
    end

    always_comb begin
        sp_next = sp_reg;
        if (do_pop) begin
            sp_next = sp_dec;
        end else if (do_push) begin
            sp_next = sp_reg + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_reg <= '0;
        end else begin
            sp_reg <= sp_next;
        end
    end

    // Stack storage needs no reset: entries above sp are never observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= {x_cur, y_cur};
        end
    end

    // Nibble 1 is x, nibble 0 is y; both share the load strobe.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_nib
            logic [3:0] nib_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    nib_reg <= 4'h0;
                end else if (bus.rgLd) begin
                    nib_reg <= nxt_loc[gi*4 +: 4];
                end
            end
        end
    endgenerate

    assign x_cur = g_nib[1].nib_reg;
    assign y_cur = g_nib[0].nib_reg;

    assign bus.cntReach = (edge_sum == 4'h0);
    assign bus.empStck  = empty;
    assign bus.fullStck = full;
    assign bus.nxtLoc   = nxt_loc;
    assign bus.curLoc   = {x_cur, y_cur};
endmodule

// File: tb/tb_maze_loc_datapath.sv
// Scoreboarded bench: directed walk/stack scenarios then random traffic against a grid/queue model.
module tb_maze_loc_datapath;
    localparam int DEPTH = 8;

    logic clk;
    logic rst;

    maze_loc_datapath_if bus ();

    maze_loc_datapath #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] nxt;
        logic [7:0] cur;
        logic       cr;
        logic       emp;
        logic       full;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    // Reference model: coordinates as integers, stack as a queue (back = top).
    int         m_x;
    int         m_y;
    logic [7:0] m_stack[$];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Monitor: outputs are settled mid-cycle, compare at the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.name, ".nxtLoc"},   bus.nxtLoc, e.nxt);
            chk({e.name, ".curLoc"},   bus.curLoc, e.cur);
            chk({e.name, ".cntReach"}, {7'd0, bus.cntReach}, {7'd0, e.cr});
            chk({e.name, ".empStck"},  {7'd0, bus.empStck},  {7'd0, e.emp});
            chk({e.name, ".fullStck"}, {7'd0, bus.fullStck}, {7'd0, e.full});
            $display("txn %-14s dir=%0d ld=%0b push=%0b pop=%0b add=%0b nxt=%h cur=%h cr=%0b emp=%0b full=%0b",
                     e.name, bus.dir, bus.rgLd, bus.push, bus.pop, bus.adderEn,
                     bus.nxtLoc, bus.curLoc, bus.cntReach, bus.empStck, bus.fullStck);
        end
    end

    function automatic exp_t model_outputs(input string nm, input bit [1:0] d,
                                           input bit po, input bit ae, input bit in_reset);
        exp_t e;
        int   op;
        int   moved;
        bit   on_x;
        on_x  = (d == 2'd1) || (d == 2'd2);
        op    = on_x ? m_x : m_y;
        moved = op + (d[0] ? 1 : -1);
        e.name = nm;
        e.cur  = 8'((m_x << 4) | m_y);
        e.cr   = (moved < 0) || (moved > 15);
        e.emp  = (m_stack.size() == 0);
        e.full = (m_stack.size() == DEPTH);
        if (in_reset) begin
            e.nxt = 8'h00;
        end else if (po) begin
            e.nxt = (m_stack.size() != 0) ? m_stack[$] : 8'h00;
        end else if (ae) begin
            if (on_x) e.nxt = 8'((((moved + 16) % 16) << 4) | m_y);
            else      e.nxt = 8'((m_x << 4) | ((moved + 16) % 16));
        end else begin
            e.nxt = e.cur;
        end
        return e;
    endfunction

    task automatic step(input bit ld, input bit [1:0] d, input bit pu, input bit po,
                        input bit ae, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = 1'b1;
        bus.rgLd    = ld;
        bus.dir     = d;
        bus.push    = pu;
        bus.pop     = po;
        bus.adderEn = ae;
        e = model_outputs(nm, d, po, ae, 1'b0);
        exp_q.push_back(e);
        if (po) begin
            if (m_stack.size() != 0) void'(m_stack.pop_back());
        end else if (pu && m_stack.size() < DEPTH) begin
            m_stack.push_back(e.cur);
        end
        if (ld) begin
            m_x = int'(e.nxt[7:4]);
            m_y = int'(e.nxt[3:0]);
        end
    endtask

    // Drops reset between edges; the check lands before the next rising edge.
    task automatic reset_step(input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_x = 0;
        m_y = 0;
        m_stack.delete();
        e = model_outputs(nm, bus.dir, bus.pop, bus.adderEn, 1'b1);
        exp_q.push_back(e);
    endtask

    task automatic walk_to(input logic [7:0] target, input bit pu_first, input string nm);
        bit first;
        first = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (m_x != int'(target[7:4])) begin
                step(1'b1, 2'd1, pu_first && first, 1'b0, 1'b1, nm);
            end else if (m_y != int'(target[3:0])) begin
                step(1'b1, 2'd3, pu_first && first, 1'b0, 1'b1, nm);
            end else begin
                break;
            end
            first = 1'b0;
        end
    endtask

    initial begin
        rst         = 1'b0;
        bus.rgLd    = 1'b0;
        bus.dir     = 2'd0;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.adderEn = 1'b0;
        m_x = 0;
        m_y = 0;

        reset_step("reset");
        // Grid edges and step adder from the origin
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, "edge_y0");
        step(1'b0, 2'd1, 1'b0, 1'b0, 1'b1, "add_x+1");
        step(1'b1, 2'd1, 1'b0, 1'b0, 1'b1, "load_10");
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, "idle");

        walk_to(8'hF5, 1'b0, "walk_F5");
        step(1'b0, 2'd1, 1'b0, 1'b0, 1'b1, "wrap_x");
        step(1'b0, 2'd3, 1'b0, 1'b0, 1'b1, "y+1");
        step(1'b0, 2'd2, 1'b0, 1'b0, 1'b1, "x-1");
        step(1'b0, 2'd2, 1'b0, 1'b0, 1'b0, "add_off");

        // LIFO order with pop+load
        walk_to(8'h12, 1'b0, "walk_12");
        step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, "push_12");
        walk_to(8'h34, 1'b0, "walk_34");
        step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, "push_34");
        walk_to(8'h56, 1'b0, "walk_56");
        step(1'b1, 2'd0, 1'b0, 1'b1, 1'b0, "pop_ld_34");
        step(1'b1, 2'd0, 1'b0, 1'b1, 1'b0, "pop_ld_12");
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, "empty");

        // Underflow and overflow
        step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, "pop_empty");
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, "still_empty");
        for (int i = 0; i < DEPTH + 1; i++) begin
            step(1'b1, 2'(i % 4), 1'b1, 1'b0, 1'b1, "push_ld");
        end
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, "full");
        step(1'b0, 2'd1, 1'b0, 1'b1, 1'b1, "pop_over_add");
        step(1'b0, 2'd0, 1'b1, 1'b1, 1'b0, "push_and_pop");
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, "after_pp");

        // Asynchronous reset with a partly filled stack
        reset_step("reset2");
        walk_to(8'h77, 1'b1, "walk_77_push");
        step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, "push_3");
        step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, "push_4");
        reset_step("async_reset");

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                reset_step("rand_reset");
            end else begin
                step($urandom_range(0, 99) < 50, 2'($urandom_range(0, 3)),
                     $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 25,
                     $urandom_range(0, 99) < 60, "rand");
            end
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
